// File: rtl/frame_decode_if.sv
// Bit-level decoder bus: framing pulses and data bits in, assembled bytes
// and frame status out. The decoder sits on the slave side.
interface frame_decode_if;
    logic       in_soc;
    logic       in_eoc;
    logic       in_error;
    logic       in_data_valid;
    logic       in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_bits;
    logic       out_soc;
    logic       out_eoc;
    logic       out_error;
    logic       parity_error;
    logic       crc_ok;

    modport master (
        output in_soc, in_eoc, in_error, in_data_valid, in_data,
        input  out_valid, out_data, out_bits, out_soc, out_eoc, out_error,
               parity_error, crc_ok
    );

    modport slave (
        input  in_soc, in_eoc, in_error, in_data_valid, in_data,
        output out_valid, out_data, out_bits, out_soc, out_eoc, out_error,
               parity_error, crc_ok
    );
endinterface

// File: rtl/frame_decode.sv
// Frame decoder: assembles LSb-first bits into bytes, checks odd parity
// (optional) and the CRC_A residue, and reports frame start/end/abort.
// All outputs are registered, so every result appears one cycle after the
// input pulse that caused it.
module frame_decode #(
    parameter bit HAS_PARITY = 1'b1
) (
    input logic           clk,
    input logic           rst,
    frame_decode_if.slave bus
);

    localparam logic [15:0] CRC_INIT = 16'h6363;
    localparam logic [15:0] CRC_POLY = 16'h8408;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;     // 8 means a parity bit is awaited
    logic [7:0]  shift_q, shift_d;
    logic [15:0] crc_q, crc_d;
    logic        par_err_q, par_err_d;
    logic        crc_ok_q, crc_ok_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bits_q, bits_d;
    logic        soc_q, soc_d;
    logic        eoc_q, eoc_d;
    logic        err_q, err_d;

    // Helpers for the current data bit.
    logic [7:0]  shift_ins;
    logic [15:0] crc_step;

    // Next-state and output decode; in_soc first, then error > eoc > data.
    always_comb begin
        // NOTE: every target gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        par_err_d = par_err_q;
        crc_ok_d  = crc_ok_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        bits_d    = bits_q;
        soc_d     = 1'b0;
        eoc_d     = 1'b0;
        err_d     = 1'b0;

        shift_ins = shift_q;
        shift_ins[bit_cnt_q[2:0]] = bus.in_data;
        crc_step  = (crc_q >> 1) ^ ((crc_q[0] ^ bus.in_data) ? CRC_POLY : 16'h0000);

        if (bus.in_soc) begin
            // A start inside a frame aborts the old one and restarts.
            err_d     = (state_q == S_DATA);
            soc_d     = 1'b1;
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
            shift_d   = 8'h00;
            par_err_d = 1'b0;
            crc_d     = CRC_INIT;
        end else if (state_q == S_DATA) begin
            if (bus.in_error) begin
                // Abort: partial byte is dropped, no end-of-frame.
                err_d     = 1'b1;
                state_d   = S_IDLE;
                bit_cnt_d = 4'd0;
                shift_d   = 8'h00;
            end else if (bus.in_eoc) begin
                eoc_d     = 1'b1;
                crc_ok_d  = (crc_q == 16'h0000);
                state_d   = S_IDLE;
                bit_cnt_d = 4'd0;
                shift_d   = 8'h00;
                if (bit_cnt_q != 4'd0) begin
                    // Partial byte, or a full byte whose parity never came.
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    bits_d  = bit_cnt_q[2:0];
                end
                if (bit_cnt_q == 4'd8) begin
                    par_err_d = 1'b1;
                end
            end else if (bus.in_data_valid) begin
                if (HAS_PARITY && (bit_cnt_q == 4'd8)) begin
                    // Parity bit: odd parity over data + parity must be 1.
                    if ((^{shift_q, bus.in_data}) == 1'b0) begin
                        par_err_d = 1'b1;
                    end
                    valid_d   = 1'b1;
                    data_d    = shift_q;
                    bits_d    = 3'd0;
                    bit_cnt_d = 4'd0;
                    shift_d   = 8'h00;
                end else begin
                    crc_d = crc_step;
                    if (!HAS_PARITY && (bit_cnt_q == 4'd7)) begin
                        valid_d   = 1'b1;
                        data_d    = shift_ins;
                        bits_d    = 3'd0;
                        bit_cnt_d = 4'd0;
                        shift_d   = 8'h00;
                    end else begin
                        shift_d   = shift_ins;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            crc_q     <= CRC_INIT;
            par_err_q <= 1'b0;
            crc_ok_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            bits_q    <= 3'd0;
            soc_q     <= 1'b0;
            eoc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            par_err_q <= par_err_d;
            crc_ok_q  <= crc_ok_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            bits_q    <= bits_d;
            soc_q     <= soc_d;
            eoc_q     <= eoc_d;
            err_q     <= err_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_data     = data_q;
    assign bus.out_bits     = bits_q;
    assign bus.out_soc      = soc_q;
    assign bus.out_eoc      = eoc_q;
    assign bus.out_error    = err_q;
    assign bus.parity_error = par_err_q;
    assign bus.crc_ok       = crc_ok_q;

endmodule

// File: tb/tb_frame_decode.sv
// Bench for frame_decode: one instance with parity, one without. Stimulus
// pushes expected events with their due cycle; a negedge monitor pops and
// compares them against the selected instance.
module tb_frame_decode;

    typedef struct {
        int          due;
        logic [7:0]  data;
        logic [2:0]  bits;
    } exp_byte_t;

    typedef struct {
        int          due;
        logic        crc_ok;
        logic        par;
    } exp_eoc_t;

    typedef struct {
        int          nbytes;
        logic [31:0] bytes;      // byte j at [8*j +: 8], sent first to last
        int          tail_bits;
        logic [7:0]  tail;
        logic [3:0]  flip;       // invert parity bit of byte j
        bit          crc_known;
        bit          crc_ok;
        bit          par;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   sel = 1'b0;            // 0: parity instance, 1: no-parity instance
    logic s_soc = 0, s_eoc = 0, s_err = 0, s_dv = 0, s_d = 0;

    int n_checks = 0;
    int n_errors = 0;
    int neg_cnt  = 0;

    exp_byte_t q_byte[$];
    exp_eoc_t  q_eoc[$];
    int        q_err[$];
    int        q_soc[$];

    bit          in_frame = 0;
    int          cur_bits = 0;
    logic [7:0]  cur_byte = 8'h00;
    logic [15:0] exp_crc  = 16'h6363;

    always #5 clk = ~clk;

    frame_decode_if bus_p ();
    frame_decode_if bus_n ();

    assign bus_p.in_soc        = !sel && s_soc;
    assign bus_p.in_eoc        = !sel && s_eoc;
    assign bus_p.in_error      = !sel && s_err;
    assign bus_p.in_data_valid = !sel && s_dv;
    assign bus_p.in_data       = !sel && s_d;
    assign bus_n.in_soc        = sel && s_soc;
    assign bus_n.in_eoc        = sel && s_eoc;
    assign bus_n.in_error      = sel && s_err;
    assign bus_n.in_data_valid = sel && s_dv;
    assign bus_n.in_data       = sel && s_d;

    frame_decode #(.HAS_PARITY(1'b1)) dut_p (.clk(clk), .rst(rst), .bus(bus_p));
    frame_decode #(.HAS_PARITY(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    logic       m_valid, m_soc, m_eoc, m_err, m_par, m_crc;
    logic [7:0] m_data;
    logic [2:0] m_bits;
    assign m_valid = sel ? bus_n.out_valid    : bus_p.out_valid;
    assign m_data  = sel ? bus_n.out_data     : bus_p.out_data;
    assign m_bits  = sel ? bus_n.out_bits     : bus_p.out_bits;
    assign m_soc   = sel ? bus_n.out_soc      : bus_p.out_soc;
    assign m_eoc   = sel ? bus_n.out_eoc      : bus_p.out_eoc;
    assign m_err   = sel ? bus_n.out_error    : bus_p.out_error;
    assign m_par   = sel ? bus_n.parity_error : bus_p.parity_error;
    assign m_crc   = sel ? bus_n.crc_ok       : bus_p.crc_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0h, expected no event (t=%0t)", name, act, $time);
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = c >> 1;
        if (c[0] ^ b) r = r ^ 16'h8408;
        return r;
    endfunction

    // Monitor: compare every output event with the scoreboard at negedge.
    initial begin
        exp_byte_t eb;
        exp_eoc_t  ee;
        int        d;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (m_valid === 1'b1) begin
                if (q_byte.size() == 0) fail("unexpected out_valid", {21'd0, m_bits, m_data});
                else begin
                    eb = q_byte.pop_front();
                    check("out_valid latency", neg_cnt, eb.due);
                    check("out_data", m_data, eb.data);
                    check("out_bits", m_bits, eb.bits);
                end
            end else if (q_byte.size() > 0 && q_byte[0].due <= neg_cnt) begin
                eb = q_byte.pop_front();
                check("missing out_valid", 0, 1);
            end
            if (m_eoc === 1'b1) begin
                if (q_eoc.size() == 0) fail("unexpected out_eoc", 1);
                else begin
                    ee = q_eoc.pop_front();
                    check("out_eoc latency", neg_cnt, ee.due);
                    check("crc_ok", m_crc, ee.crc_ok);
                    check("parity_error", m_par, ee.par);
                end
            end else if (q_eoc.size() > 0 && q_eoc[0].due <= neg_cnt) begin
                ee = q_eoc.pop_front();
                check("missing out_eoc", 0, 1);
            end
            if (m_err === 1'b1) begin
                if (q_err.size() == 0) fail("unexpected out_error", 1);
                else begin
                    d = q_err.pop_front();
                    check("out_error latency", neg_cnt, d);
                end
            end else if (q_err.size() > 0 && q_err[0] <= neg_cnt) begin
                d = q_err.pop_front();
                check("missing out_error", 0, 1);
            end
            if (m_soc === 1'b1) begin
                if (q_soc.size() == 0) fail("unexpected out_soc", 1);
                else begin
                    d = q_soc.pop_front();
                    check("out_soc latency", neg_cnt, d);
                end
            end else if (q_soc.size() > 0 && q_soc[0] <= neg_cnt) begin
                d = q_soc.pop_front();
                check("missing out_soc", 0, 1);
            end
        end
    end

    task automatic send(input logic soc, input logic eoc, input logic err,
                        input logic dv, input logic d);
        @(posedge clk);
        #1;
        s_soc = soc; s_eoc = eoc; s_err = err; s_dv = dv; s_d = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 0, 0, 0, 0);
    endtask

    task automatic do_soc();
        send(1, 0, 0, 0, 0);
        if (in_frame) q_err.push_back(neg_cnt + 2);
        q_soc.push_back(neg_cnt + 2);
        in_frame = 1;
        cur_bits = 0;
        cur_byte = 8'h00;
        exp_crc  = 16'h6363;
    endtask

    task automatic do_bit(input logic b, input bit is_par);
        send(0, 0, 0, 1, b);
        if (!is_par) begin
            exp_crc = crc_model(exp_crc, b);
            cur_byte[cur_bits[2:0]] = b;
            cur_bits++;
        end
    endtask

    task automatic do_byte(input logic [7:0] b, input bit flip);
        exp_byte_t eb;
        for (int k = 0; k < 8; k++) do_bit(b[k], 0);
        if (!sel) do_bit((~^b) ^ flip, 1);
        eb.due = neg_cnt + 2; eb.data = b; eb.bits = 3'd0;
        q_byte.push_back(eb);
        cur_bits = 0;
        cur_byte = 8'h00;
    endtask

    task automatic do_eoc(input bit par, input bit crc_known, input bit crc_val, input bit also_dv);
        exp_byte_t eb;
        exp_eoc_t  ee;
        send(0, 1, 0, also_dv, 1'b1);
        if (cur_bits > 0) begin
            eb.due = neg_cnt + 2; eb.data = cur_byte; eb.bits = 3'(cur_bits % 8);
            q_byte.push_back(eb);
        end
        ee.due = neg_cnt + 2;
        ee.crc_ok = crc_known ? crc_val : (exp_crc == 16'h0000);
        ee.par = par;
        q_eoc.push_back(ee);
        in_frame = 0;
        cur_bits = 0;
        cur_byte = 8'h00;
    endtask

    task automatic do_err(input bit also_eoc);
        send(0, also_eoc, 1, 0, 0);
        q_err.push_back(neg_cnt + 2);
        in_frame = 0;
        cur_bits = 0;
        cur_byte = 8'h00;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " parity inst"},
              {15'd0, bus_p.out_valid, bus_p.out_data, bus_p.out_bits, bus_p.out_soc,
               bus_p.out_eoc, bus_p.out_error, bus_p.parity_error, bus_p.crc_ok}, 32'd0);
        check({name, " no-parity inst"},
              {15'd0, bus_n.out_valid, bus_n.out_data, bus_n.out_bits, bus_n.out_soc,
               bus_n.out_eoc, bus_n.out_error, bus_n.parity_error, bus_n.crc_ok}, 32'd0);
    endtask

    frame_vec_t vecs[6];

    initial begin
        logic [31:0] bv;
        logic [7:0]  tv;
        logic [7:0]  reqa;

        vecs[0] = '{nbytes: 0, bytes: 32'h0,        tail_bits: 7, tail: 8'h26, flip: 4'h0,
                    crc_known: 0, crc_ok: 0, par: 0};                        // REQA
        vecs[1] = '{nbytes: 2, bytes: 32'h2093,     tail_bits: 0, tail: 8'h00, flip: 4'h0,
                    crc_known: 0, crc_ok: 0, par: 0};                        // SEL 93 20
        vecs[2] = '{nbytes: 2, bytes: 32'h2093,     tail_bits: 0, tail: 8'h00, flip: 4'h1,
                    crc_known: 0, crc_ok: 0, par: 1};                        // bad parity
        vecs[3] = '{nbytes: 4, bytes: 32'hCD570050, tail_bits: 0, tail: 8'h00, flip: 4'h0,
                    crc_known: 1, crc_ok: 1, par: 0};                        // HLTA good
        vecs[4] = '{nbytes: 4, bytes: 32'hCC570050, tail_bits: 0, tail: 8'h00, flip: 4'h0,
                    crc_known: 1, crc_ok: 0, par: 0};                        // HLTA bad
        vecs[5] = '{nbytes: 1, bytes: 32'h000000A5, tail_bits: 3, tail: 8'h05, flip: 4'h0,
                    crc_known: 0, crc_ok: 0, par: 0};                        // byte + 3 bits

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset state");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Table-driven frames on the parity instance.
        for (int i = 0; i < 6; i++) begin
            do_soc();
            bv = vecs[i].bytes;
            for (int j = 0; j < vecs[i].nbytes; j++) do_byte(bv[8*j +: 8], vecs[i].flip[j]);
            tv = vecs[i].tail;
            for (int k = 0; k < vecs[i].tail_bits; k++) do_bit(tv[k], 0);
            do_eoc(vecs[i].par, vecs[i].crc_known, vecs[i].crc_ok, 0);
            idle(2);
        end

        // Error after 3 bits of the second byte, then REQA right away.
        reqa = 8'h26;
        do_soc();
        do_byte(8'h93, 0);
        for (int k = 0; k < 3; k++) do_bit(k == 0 ? 1'b0 : 1'b0, 0);
        do_err(0);
        do_soc();
        for (int k = 0; k < 7; k++) do_bit(reqa[k], 0);
        do_eoc(0, 0, 0, 0);
        idle(2);

        // End of frame while the parity bit is still awaited.
        reqa = 8'h3C;
        do_soc();
        for (int k = 0; k < 8; k++) do_bit(reqa[k], 0);
        do_eoc(1, 0, 0, 0);
        idle(2);

        // Start inside a frame: abort plus restart.
        do_soc();
        for (int k = 0; k < 4; k++) do_bit(1'b1, 0);
        do_soc();
        do_byte(8'h26, 0);
        do_eoc(0, 0, 0, 0);
        idle(2);

        // Priority: error beats eoc; eoc beats a data bit.
        do_soc();
        do_bit(1'b1, 0);
        do_bit(1'b0, 0);
        do_err(1);
        do_soc();
        do_bit(1'b1, 0);
        do_bit(1'b1, 0);
        do_eoc(0, 0, 0, 1);
        idle(2);

        // Inputs other than in_soc are ignored in IDLE.
        send(0, 0, 0, 1, 1);
        send(0, 1, 0, 0, 0);
        send(0, 0, 1, 0, 0);
        idle(3);

        // Reset mid-byte: silent abandon.
        do_soc();
        for (int k = 0; k < 3; k++) do_bit(1'b1, 0);
        @(posedge clk);
        #1;
        s_dv = 0; s_d = 0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("mid-frame reset");
        @(posedge clk);
        #1 rst = 1'b0;
        in_frame = 0;
        cur_bits = 0;
        cur_byte = 8'h00;
        idle(4);

        // No-parity instance: single byte A5 on the 8th bit.
        sel = 1'b1;
        idle(2);
        do_soc();
        do_byte(8'hA5, 0);
        do_eoc(0, 0, 0, 0);
        idle(3);
        sel = 1'b0;
        idle(2);

        // Nothing left outstanding.
        check("pending bytes", q_byte.size(), 0);
        check("pending eoc", q_eoc.size(), 0);
        check("pending error", q_err.size(), 0);
        check("pending soc", q_soc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_decode.md
FRAME_DECODE -- requirements
Module: frame_decode

Interface
REQ-001 SHALL have parameter HAS_PARITY, default 1; 1 means each full data byte is followed by one odd-parity bit, 0 means no parity bits are present.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_soc, input, 1, one-cycle pulse marking start of communication from the sequence decoder.
REQ-005 SHALL have port in_eoc, input, 1, one-cycle pulse marking end of communication.
REQ-006 SHALL have port in_error, input, 1, one-cycle pulse flagging an illegal sequence.
REQ-007 SHALL have port in_data_valid, input, 1, qualifies in_data for one cycle.
REQ-008 SHALL have port in_data, input, 1, received bit (data or parity), LSb of each byte first.
REQ-009 SHALL have port out_valid, output, 1, one-cycle pulse when out_data and out_bits are valid.
REQ-010 SHALL have port out_data, output, 8, assembled byte; unreceived high bits are 0.
REQ-011 SHALL have port out_bits, output, 3, number of valid bits in out_data, where 0 means 8.
REQ-012 SHALL have port out_soc, output, 1, registered copy of an accepted in_soc.
REQ-013 SHALL have port out_eoc, output, 1, one-cycle pulse ending a frame.
REQ-014 SHALL have port out_error, output, 1, one-cycle pulse when a frame is aborted.
REQ-015 SHALL have port parity_error, output, 1, sticky per-frame flag that is valid while out_eoc is high.
REQ-016 SHALL have port crc_ok, output, 1, CRC_A residue check that is valid while out_eoc is high.

Function
REQ-017 SHALL implement states IDLE and DATA; the bit counter bit_cnt SHALL take values 0..8, where 8 means a parity bit is awaited.
REQ-018 SHALL, on in_soc in any state, enter DATA, clear bit_cnt, the shift register and parity_error, and load crc with 16'h6363.
REQ-019 SHALL ignore in_data_valid, in_eoc and in_error while in IDLE.
REQ-020 SHALL, on each data bit in DATA, shift it into byte position bit_cnt, increment bit_cnt, and update crc as crc = (crc>>1) ^ (16'h8408 if crc[0]^bit is 1, else 0).
REQ-021 SHALL, when HAS_PARITY=1 and bit_cnt=8, treat the next bit as parity: if XOR of the 8 data bits XOR parity is 0 it SHALL set parity_error; in either case it SHALL emit the byte with out_bits=0 and clear bit_cnt; the parity bit SHALL NOT enter the CRC.
REQ-022 SHALL, when HAS_PARITY=0, emit the byte on the 8th data bit and clear bit_cnt.
REQ-023 SHALL have a latency of exactly 1 cycle from the input pulse that completes a byte to out_valid.
REQ-024 SHALL, on in_eoc in DATA with bit_cnt 1..7, emit the partial byte with out_bits=bit_cnt and out_valid in the same cycle as out_eoc.
REQ-025 SHALL, on in_eoc in DATA with bit_cnt=8 and HAS_PARITY=1 (parity missing), emit the byte with out_bits=0 and set parity_error.
REQ-026 SHALL, on in_eoc in DATA, pulse out_eoc 1 cycle later, present crc_ok = (crc == 16'h0000) and the final parity_error alongside it, then return to IDLE.
REQ-027 SHALL, on in_error in DATA, pulse out_error 1 cycle later, discard any partial byte, produce no out_eoc, and return to IDLE.
REQ-028 SHALL, on in_soc in DATA, pulse out_error and out_soc together and restart the frame.
REQ-029 SHALL apply the priority in_error > in_eoc > in_data_valid when these coincide; lower-priority events in that cycle SHALL be dropped.
REQ-030 SHALL drive out_soc 1 cycle after in_soc.

Reset
REQ-031 SHALL, while rst=1, force state=IDLE, bit_cnt=0, crc=16'h6363, out_valid=0, out_data=0, out_bits=0, out_soc=0, out_eoc=0, out_error=0, parity_error=0 and crc_ok=0.
REQ-032 SHALL, when rst is asserted mid-frame, abandon the frame silently, with no out_eoc and no out_error; the next in_soc SHALL decode normally.

Verification
REQ-033 SHALL verify a REQA short frame: soc, bits 0,1,1,0,0,1,0, eoc -> one out_valid with out_data=8'h26 and out_bits=7, parity_error=0, and out_eoc.
REQ-034 SHALL verify SEL 93 20 with parity: bits of 8'h93 + parity 1 and bits of 8'h20 + parity 0 -> two bytes with out_bits=0 and parity_error=0.
REQ-035 SHALL verify the same frame with the first parity bit inverted -> both bytes still emitted and parity_error=1 at out_eoc.
REQ-036 SHALL verify HLTA 50 00 57 CD with parity -> crc_ok=1; the same frame with CD replaced by CC -> crc_ok=0.
REQ-037 SHALL verify in_error after 3 bits of byte 2 -> byte 1 emitted, out_error pulse, no out_eoc, no partial byte; an immediately following REQA decodes correctly.
REQ-038 SHALL verify rst asserted mid-byte and HAS_PARITY=0 frame 8'hA5 -> after reset all outputs are 0 and no eoc occurs; with HAS_PARITY=0 a single out_valid of 8'hA5 appears 1 cycle after the 8th bit.
